// File: rtl/video_src_ctrl.sv
// video_src_ctrl: selects core video once its vsync is locked, otherwise the noise generator.
// Define VIDSRC_FADE_EN to fade the noise colour in after a loss of lock.
module video_src_ctrl #(
  parameter int LOCK_FRAMES = 3,
  parameter int MIN_FRAME = 100000,
  parameter int MAX_FRAME = 400000
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       white_noise,
  input  logic       core_hs,
  input  logic       core_vs,
  input  logic [5:0] core_r,
  input  logic [5:0] core_g,
  input  logic [5:0] core_b,
  input  logic       noise_hs,
  input  logic       noise_vs,
  input  logic [5:0] noise_r,
  input  logic [5:0] noise_g,
  input  logic [5:0] noise_b,
  output logic       noise_en,
  output logic       hs,
  output logic       vs,
  output logic [5:0] r,
  output logic [5:0] g,
  output logic [5:0] b,
  output logic       locked
);
  localparam logic [19:0] SAT = 20'(MAX_FRAME + 1);
  localparam logic [19:0] MINF = 20'(MIN_FRAME);
  localparam logic [19:0] MAXF = 20'(MAX_FRAME);
  localparam logic [7:0] LAST = 8'(LOCK_FRAMES - 1);
  typedef enum logic {NOSIG, LOCKED} state_t;
  state_t state, nxt;
  logic core_vs_d, rise, valid, lost;
  logic [19:0] cnt;
  logic [7:0] good_cnt;
  logic [5:0] nr, ng, nb;
  assign rise = core_vs & ~core_vs_d;
  assign valid = rise && cnt >= MINF && cnt <= MAXF;
  // a saturated counter wins over a coincident rise
  assign lost = cnt == SAT || (rise && cnt < MINF);
  always_comb
    nxt = state == LOCKED ? (lost ? NOSIG : LOCKED) : (valid && good_cnt == LAST ? LOCKED : NOSIG);
`ifdef VIDSRC_FADE_EN
  logic noise_vs_d;
  logic [2:0] atten;
  always_ff @(posedge pclk)
    if (!reset_n) begin
      noise_vs_d <= 1'b0;
      atten <= 3'd0;
    end else begin
      noise_vs_d <= noise_vs;
      if (state == LOCKED && nxt == NOSIG) atten <= 3'd5;
      else if (noise_vs && !noise_vs_d && atten != 3'd0) atten <= atten - 3'd1;
    end
  assign nr = noise_r >> atten;
  assign ng = noise_g >> atten;
  assign nb = noise_b >> atten;
`else
  assign nr = noise_r;
  assign ng = noise_g;
  assign nb = noise_b;
`endif
  always_ff @(posedge pclk)
    if (!reset_n) begin
      state <= NOSIG;
      core_vs_d <= 1'b0;
      cnt <= SAT;
      good_cnt <= 8'd0;
      locked <= 1'b0;
      noise_en <= 1'b0;
      hs <= 1'b0;
      vs <= 1'b0;
      r <= 6'd0;
      g <= 6'd0;
      b <= 6'd0;
    end else begin
      core_vs_d <= core_vs;
      cnt <= rise ? 20'd1 : (cnt == SAT ? SAT : cnt + 20'd1);
      state <= nxt;
      good_cnt <= (nxt != state || (rise && !valid)) ? 8'd0 : good_cnt + 8'(valid && state == NOSIG);
      // source switches together with the lock decision so core video starts on a vsync
      locked <= nxt == LOCKED;
      noise_en <= nxt == NOSIG && white_noise;
      hs <= nxt == LOCKED ? core_hs : noise_hs;
      vs <= nxt == LOCKED ? core_vs : noise_vs;
      r <= nxt == LOCKED ? core_r : (white_noise ? nr : 6'd0);
      g <= nxt == LOCKED ? core_g : (white_noise ? ng : 6'd0);
      b <= nxt == LOCKED ? core_b : (white_noise ? nb : 6'd0);
    end
endmodule

// File: tb/tb_video_src_ctrl.sv
// tb_video_src_ctrl: directed stimulus with a queued-expectation scoreboard for video_src_ctrl.
module tb_video_src_ctrl;
  localparam int LF = 3, MINF = 20, MAXF = 80, SAT = MAXF + 1;
`ifdef VIDSRC_FADE_EN
  localparam logic [5:0] LOSS_R = 6'h01;
`else
  localparam logic [5:0] LOSS_R = 6'h2A;
`endif
  logic pclk = 0, reset_n = 0, white_noise = 1, core_hs = 0, core_vs = 0, noise_hs = 0, noise_vs = 0;
  logic [5:0] core_r = 0, core_g = 6'h15, core_b = 6'h2B, noise_r = 6'h2A, noise_g = 6'h0F, noise_b = 6'h30;
  logic noise_en, hs, vs, locked;
  logic [5:0] r, g, b;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int at; string name; logic lk; logic ne; logic [5:0] r;} exp_t;
  exp_t q[$];

  video_src_ctrl #(.LOCK_FRAMES(LF), .MIN_FRAME(MINF), .MAX_FRAME(MAXF)) dut (
    .pclk(pclk), .reset_n(reset_n), .white_noise(white_noise),
    .core_hs(core_hs), .core_vs(core_vs), .core_r(core_r), .core_g(core_g), .core_b(core_b),
    .noise_hs(noise_hs), .noise_vs(noise_vs), .noise_r(noise_r), .noise_g(noise_g), .noise_b(noise_b),
    .noise_en(noise_en), .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .locked(locked));

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk)
    while (q.size() != 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.at != cyc || locked !== e.lk || noise_en !== e.ne || r !== e.r) begin
        failures++;
        $display("FAIL %s cycle %0d: got locked=%b noise_en=%b r=%h, want locked=%b noise_en=%b r=%h at cycle %0d",
                 e.name, cyc, locked, noise_en, r, e.lk, e.ne, e.r, e.at);
      end
    end

  task automatic step();
    @(posedge pclk);
    #1;
    core_r = 6'(cyc);
  endtask

  task automatic expect_at(input int at, input string name, input logic lk, input logic ne, input logic [5:0] rr);
    exp_t e;
    e.at = at; e.name = name; e.lk = lk; e.ne = ne; e.r = rr;
    q.push_back(e);
  endtask

  task automatic pulse(output int k);
    core_vs = 1;
    k = cyc;
    step();
    core_vs = 0;
  endtask

  task automatic gap(input int p);
    repeat (p - 1) step();
  endtask

  initial begin
    int k;
    step(); step();
    expect_at(cyc + 1, "reset", 0, 0, 6'h00);
    step();
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL reset_direct locked=%b", locked); end
    checks++;
    if (noise_en !== 1'b0) begin failures++; $display("FAIL reset_direct noise_en=%b", noise_en); end
    checks++;
    if (r !== 6'h00) begin failures++; $display("FAIL reset_direct r=%h", r); end
    reset_n = 1;
    expect_at(cyc + 1, "idle_noise", 0, 1, 6'h2A);
    step(); step();
    white_noise = 0;
    expect_at(cyc + 1, "noise_off", 0, 0, 6'h00);
    step();
    white_noise = 1;
    expect_at(cyc + 1, "noise_on", 0, 1, 6'h2A);
    step();
    pulse(k); gap(40);
    pulse(k); gap(40);
    pulse(k); expect_at(k + 1, "no_lock_rise3", 0, 1, 6'h2A); gap(40);
    pulse(k);
    expect_at(k + 1, "lock_rise4", 1, 0, 6'(k));
    expect_at(k + 5, "core_delay", 1, 0, 6'(k + 4));
    expect_at(k + SAT, "hold_lock", 1, 0, 6'(k + SAT - 1));
    expect_at(k + SAT + 1, "loss", 0, 1, LOSS_R);
    gap(SAT + 6);
    pulse(k); gap(40);
    pulse(k); gap(40);
    pulse(k); gap(10);
    pulse(k); expect_at(k + 1, "short_no_lock", 0, 1, LOSS_R); gap(40);
    pulse(k); gap(40);
    pulse(k); expect_at(k + 1, "no_lock_after_short", 0, 1, LOSS_R); gap(40);
    pulse(k); expect_at(k + 1, "relock_after_short", 1, 0, 6'(k)); gap(10);
    pulse(k); expect_at(k + 1, "glitch_drop", 0, 1, LOSS_R); gap(MINF);
    pulse(k); gap(MAXF);
    pulse(k); gap(40);
    pulse(k); expect_at(k + 1, "lock_min_max", 1, 0, 6'(k));
    step(); step(); step();
    reset_n = 0;
    expect_at(cyc + 1, "mid_reset", 0, 0, 6'h00);
    step();
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL mid_reset_direct locked=%b", locked); end
    checks++;
    if (noise_en !== 1'b0) begin failures++; $display("FAIL mid_reset_direct noise_en=%b", noise_en); end
    checks++;
    if (r !== 6'h00) begin failures++; $display("FAIL mid_reset_direct r=%h", r); end
    reset_n = 1;
    expect_at(cyc + 1, "post_reset", 0, 1, 6'h2A);
    step();
    pulse(k); gap(40);
    pulse(k); gap(40);
    pulse(k); expect_at(k + 1, "relock_rise3", 0, 1, 6'h2A); gap(40);
    pulse(k); expect_at(k + 1, "relock_rise4", 1, 0, 6'(k));
`ifdef VIDSRC_FADE_EN
    noise_r = 6'h3F;
    expect_at(k + SAT + 1, "fade0", 0, 1, 6'h01);
    gap(SAT + 4);
    for (int i = 1; i <= 5; i++) begin
      int t;
      noise_vs = 1;
      t = cyc;
      step();
      noise_vs = 0;
      expect_at(t + 3, "fade_step", 0, 1, 6'h3F >> (5 - i));
      step(); step(); step();
    end
`endif
    for (int i = 0; i < 200 && q.size() != 0; i++) step();
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: expectation for cycle %0d never reached (now %0d)", e.name, e.at, cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
